corelet_ctrl: RTL and testbench

//  Instruction sequencer for the corelet datapath (L0 -> mac_array -> OFIFO -> SFP bank).

---
 rtl/corelet_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: autonomous instruction sequencer for the corelet datapath
// (L0 -> mac_array -> OFIFO -> SFP). Runs one weight-stationary pass of len_kij kernel
// positions, each loading row weight vectors, then streaming N activation vectors and
// draining N output rows into the SFP accumulators.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start, simd_in     one-cycle start pulse (IDLE only) and mode sampled with it
//   l0_o_full          L0 cannot accept a write
//   l0_o_ready         L0 holds readable data in all lanes
//   ofifo_valid        OFIFO holds a complete output row
//   l0_wr, l0_rd       L0 write / read strobes
//   mac_inst           00 idle, 01 kernel load, 10 execute
//   ofifo_rd, acc      OFIFO read strobe and SFP accumulate (one cycle after ofifo_rd)
//   simd               latched mode
//   mem_addr           SRAM read address feeding L0, +1 per l0_wr
//   kij                current kernel position
//   busy, done         busy outside IDLE; done pulses for one cycle at the end of a pass
//
// Every output is a flop: strobes are decided from the current state and inputs and take
// effect in the following cycle, so there is no input-to-output combinational path.
module corelet_ctrl #(
   parameter int unsigned row     = 8,
   parameter int unsigned col     = 8,
   parameter int unsigned len_kij = 9,
   parameter int unsigned len_nij = 36,
   parameter int unsigned addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               simd_in,
   input  logic               l0_o_full,
   input  logic               l0_o_ready,
   input  logic               ofifo_valid,
   output logic               l0_wr,
   output logic               l0_rd,
   output logic [1:0]         mac_inst,
   output logic               ofifo_rd,
   output logic               acc,
   output logic               simd,
   output logic [addr_bw-1:0] mem_addr,
   output logic [3:0]         kij,
   output logic               busy,
   output logic               done
);

   localparam int unsigned Flush  = row + col;
   localparam int unsigned NSimd  = (len_nij + 1) / 2;
   localparam int unsigned CntMax = (Flush > len_nij) ? Flush : len_nij;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StIdle, StWFill, StWLoad, StWFlush, StXRun, StXFlush, StDrain, StFin
   } state_t;

   state_t             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;     // per-state strobe/cycle counter
   logic [CntW-1:0]    wcnt_q, wcnt_d;   // activation writes in X_RUN
   logic [3:0]         kij_q, kij_d;
   logic               simd_q, simd_d;
   logic [addr_bw-1:0] mem_addr_q, mem_addr_d;
   logic               l0_wr_q, l0_wr_d;
   logic               l0_rd_q, l0_rd_d;
   logic [1:0]         mac_q, mac_d;
   logic               ofifo_rd_q, ofifo_rd_d;
   logic               acc_q;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CntW-1:0]    n_vec;

   // Two 2-bit activations share one vector in SIMD mode.
   assign n_vec = simd_q ? CntW'(NSimd) : CntW'(len_nij);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wcnt_d     = wcnt_q;
      kij_d      = kij_q;
      simd_d     = simd_q;
      // The address steps after the cycle that carried the write strobe.
      mem_addr_d = l0_wr_q ? mem_addr_q + addr_bw'(1) : mem_addr_q;
      l0_wr_d    = 1'b0;
      l0_rd_d    = 1'b0;
      mac_d      = 2'b00;
      ofifo_rd_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StWFill;
               simd_d     = simd_in;
               kij_d      = '0;
               mem_addr_d = '0;
               cnt_d      = '0;
               wcnt_d     = '0;
            end
         end
         StWFill: begin
            l0_wr_d = !l0_o_full;
            if (l0_wr_d) begin
               if (cnt_q == CntW'(row - 1)) begin
                  cnt_d   = '0;
                  state_d = StWLoad;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StWLoad: begin
            l0_rd_d = l0_o_ready;
            if (l0_rd_d) begin
               mac_d = 2'b01;
               if (cnt_q == CntW'(row - 1)) begin
                  cnt_d   = '0;
                  state_d = StWFlush;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StWFlush: begin
            if (cnt_q == CntW'(Flush - 1)) begin
               cnt_d   = '0;
               state_d = StXRun;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StXRun: begin
            // Write and read sides advance independently; both may fire together.
            l0_wr_d = (wcnt_q < n_vec) && !l0_o_full;
            if (l0_wr_d) begin
               wcnt_d = wcnt_q + CntW'(1);
            end
            l0_rd_d = (cnt_q < n_vec) && l0_o_ready;
            if (l0_rd_d) begin
               mac_d = 2'b10;
               if (cnt_q == n_vec - CntW'(1)) begin
                  cnt_d   = '0;
                  wcnt_d  = '0;
                  state_d = StXFlush;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StXFlush: begin
            if (cnt_q == CntW'(Flush - 1)) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDrain: begin
            ofifo_rd_d = ofifo_valid && (cnt_q < n_vec);
            if (ofifo_rd_d) begin
               cnt_d = cnt_q + CntW'(1);
            end
            // Leave only once the strobe for the last read has turned into acc.
            if (cnt_q == n_vec && !ofifo_rd_q) begin
               cnt_d   = '0;
               kij_d   = kij_q + 4'd1;
               state_d = (kij_q < 4'(len_kij - 1)) ? StWFill : StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_d = (state_d != StIdle);
   assign done_d = (state_d == StFin);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wcnt_q     <= '0;
         kij_q      <= '0;
         simd_q     <= 1'b0;
         mem_addr_q <= '0;
         l0_wr_q    <= 1'b0;
         l0_rd_q    <= 1'b0;
         mac_q      <= 2'b00;
         ofifo_rd_q <= 1'b0;
         acc_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wcnt_q     <= wcnt_d;
         kij_q      <= kij_d;
         simd_q     <= simd_d;
         mem_addr_q <= mem_addr_d;
         l0_wr_q    <= l0_wr_d;
         l0_rd_q    <= l0_rd_d;
         mac_q      <= mac_d;
         ofifo_rd_q <= ofifo_rd_d;
         acc_q      <= ofifo_rd_q;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign l0_wr    = l0_wr_q;
   assign l0_rd    = l0_rd_q;
   assign mac_inst = mac_q;
   assign ofifo_rd = ofifo_rd_q;
   assign acc      = acc_q;
   assign simd     = simd_q;
   assign mem_addr = mem_addr_q;
   assign kij      = kij_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl. Each pass pushes its expected strobe totals to a
// scoreboard when start is driven; the entry is popped and compared when the pass ends.
module tb_corelet_ctrl;

   localparam int unsigned Row    = 8;
   localparam int unsigned Col    = 8;
   localparam int unsigned LenKij = 9;
   localparam int unsigned LenNij = 36;
   localparam int unsigned AddrBw = 11;

   logic              clk = 1'b0;
   logic              reset, start, simd_in, l0_o_full, l0_o_ready, ofifo_valid;
   logic              l0_wr, l0_rd, ofifo_rd, acc, simd, busy, done;
   logic [1:0]        mac_inst;
   logic [AddrBw-1:0] mem_addr;
   logic [3:0]        kij;

   always #5 clk = ~clk;

   corelet_ctrl #(
      .row     (Row),
      .col     (Col),
      .len_kij (LenKij),
      .len_nij (LenNij),
      .addr_bw (AddrBw)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .simd_in     (simd_in),
      .l0_o_full   (l0_o_full),
      .l0_o_ready  (l0_o_ready),
      .ofifo_valid (ofifo_valid),
      .l0_wr       (l0_wr),
      .l0_rd       (l0_rd),
      .mac_inst    (mac_inst),
      .ofifo_rd    (ofifo_rd),
      .acc         (acc),
      .simd        (simd),
      .mem_addr    (mem_addr),
      .kij         (kij),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      int wr;
      int ld;
      int ex;
      int ofrd;
      int acc;
      int done;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   n_wr, n_ld, n_ex, n_ofrd, n_acc, n_done, n_lat, cyc;
   logic prev_ofrd;
   bit   toggle_valid;
   int   load_ideal, load_hold, load_tmp;
   bit   seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one cycle and sample at the falling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (l0_wr) n_wr++;
      if (mac_inst == 2'b01) n_ld++;
      if (mac_inst == 2'b10) n_ex++;
      if (ofifo_rd) n_ofrd++;
      if (acc) n_acc++;
      if (done) n_done++;
      if (acc !== prev_ofrd) n_lat++;
      prev_ofrd = ofifo_rd;
      if (toggle_valid) ofifo_valid = ~ofifo_valid;
   endtask

   task automatic clear_counts();
      n_wr = 0; n_ld = 0; n_ex = 0; n_ofrd = 0; n_acc = 0; n_done = 0; n_lat = 0;
      cyc = 0; prev_ofrd = 1'b0;
   endtask

   function automatic exp_t make_exp(input logic sm);
      exp_t e;
      int   n;
      n      = sm ? (LenNij + 1) / 2 : LenNij;
      e.wr   = LenKij * (Row + n);
      e.ld   = LenKij * Row;
      e.ex   = LenKij * n;
      e.ofrd = LenKij * n;
      e.acc  = LenKij * n;
      e.done = 1;
      return e;
   endfunction

   // One full pass. hold_after >= 0 holds l0_o_full for 5 cycles once that many writes
   // have been seen; pulse_busy fires a stray start (with simd_in = 1) during execute.
   task automatic run_pass(input logic sm, input int hold_after, input bit pulse_busy,
                           output int load_cyc);
      exp_t              e;
      bit                held, pulsed, fin;
      int                hold_bad;
      logic [AddrBw-1:0] a0;
      held = 0; pulsed = 0; fin = 0; hold_bad = 0; a0 = '0;
      clear_counts();
      load_cyc = -1;
      sb.push_back(make_exp(sm));
      simd_in = sm;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      simd_in = 1'b0;
      check("start_kij", 32'(kij), 0);
      check("start_addr", 32'(mem_addr), 0);
      check("start_busy", 32'(busy), 1);
      for (int i = 0; i < 5000 && !fin; i++) begin
         if (hold_after >= 0 && !held && n_wr == hold_after) begin
            held      = 1;
            l0_o_full = 1'b1;
            for (int j = 0; j < 5; j++) begin
               tick();
               if (j == 0) a0 = mem_addr;
               if (l0_wr !== 1'b0 || mem_addr !== a0) hold_bad++;
            end
            l0_o_full = 1'b0;
            check("hold_frozen", 32'(hold_bad), 0);
         end
         if (pulse_busy && !pulsed && n_ex == 10) begin
            pulsed  = 1;
            start   = 1'b1;
            simd_in = 1'b1;
            tick();
            start   = 1'b0;
            simd_in = 1'b0;
         end
         tick();
         if (load_cyc < 0 && mac_inst == 2'b01) load_cyc = cyc;
         if (busy === 1'b0) fin = 1;
      end
      check("pass_end", 32'(fin), 1);
      e = sb.pop_front();
      check("l0_wr_cnt", 32'(n_wr), 32'(e.wr));
      check("load_cnt", 32'(n_ld), 32'(e.ld));
      check("exec_cnt", 32'(n_ex), 32'(e.ex));
      check("ofifo_rd_cnt", 32'(n_ofrd), 32'(e.ofrd));
      check("acc_cnt", 32'(n_acc), 32'(e.acc));
      check("done_cnt", 32'(n_done), 32'(e.done));
      check("acc_latency", 32'(n_lat), 0);
      check("end_addr", 32'(mem_addr), 32'(e.wr % (1 << AddrBw)));
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      simd_in      = 1'b0;
      l0_o_full    = 1'b0;
      l0_o_ready   = 1'b1;
      ofifo_valid  = 1'b1;
      toggle_valid = 0;
      clear_counts();
      tick();
      tick();
      check("reset_outs", 32'({l0_wr, l0_rd, mac_inst, ofifo_rd, acc, simd, mem_addr, kij,
                                busy, done}), 0);
      reset = 1'b0;
      tick();

      // Abort a pass mid-execute with an asynchronous reset.
      clear_counts();
      simd_in = 1'b1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      simd_in = 1'b0;
      seen    = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
         tick();
         if (mac_inst == 2'b10) seen = 1;
      end
      check("reach_xrun", 32'(seen), 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outs", 32'({l0_wr, l0_rd, mac_inst, ofifo_rd, acc, simd, mem_addr,
                                      kij, busy, done}), 0);
      @(negedge clk);
      reset = 1'b0;
      clear_counts();
      tick();
      tick();
      tick();
      check("abort_no_done", 32'(n_done), 0);
      check("abort_idle", 32'(busy), 0);

      // Ideal handshakes, 4-bit mode.
      run_pass(1'b0, -1, 1'b0, load_ideal);
      check("simd_mode0", 32'(simd), 0);

      // SIMD mode; mode holds after the pass.
      run_pass(1'b1, -1, 1'b0, load_tmp);
      check("simd_after_pass", 32'(simd), 1);
      tick();
      tick();
      tick();
      check("simd_held_idle", 32'(simd), 1);

      // L0 full for 5 cycles during the first weight fill.
      run_pass(1'b0, 3, 1'b0, load_hold);
      check("fill_delay", 32'(load_hold), 32'(load_ideal + 5));
      check("simd_relatched", 32'(simd), 0);

      // OFIFO valid on every other cycle.
      toggle_valid = 1;
      run_pass(1'b0, -1, 1'b0, load_tmp);
      toggle_valid = 0;
      ofifo_valid  = 1'b1;

      // Stray start while busy is ignored.
      run_pass(1'b0, -1, 1'b1, load_tmp);
      check("stray_start_simd", 32'(simd), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
